jpeg_bit_reader: RTL and testbench
==================================

# jpeg_bit_reader

Bit-level front end of the JPEG entropy decoder, the receive-side counterpart of the encoder's byte-stuffing bit packer. It accepts entropy-coded-segment bytes and removes stuffed 0x00 bytes that follow 0xFF. It detects and reports markers, and presents the next 16 bits of the stream MSB-aligned so the Huffman decoder can peek and consume a variable-length field of 0–16 bits per cycle.

## Interface
Parameters:
- ACC_W, 32, accumulator width in bits; must be ≥ 24 and a multiple of 8.
- PEEK_W, 16, width of the peek window and maximum consume length.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_byte  in  8  next stream byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  block accepts in_byte this cycle; transfer occurs when in_valid && in_ready.
- peek_bits  out  PEEK_W  next stream bits, MSB = oldest; bits beyond bits_avail read as 0.
- bits_avail  out  $clog2(ACC_W+1)  number of valid bits held.
- consume_en  in  1  remove consume_len bits this cycle.
- consume_len  in  5  bits to remove, 0..PEEK_W.
- marker_valid  out  1  a marker has been detected.
- marker_code  out  8  second byte of the marker, e.g. 0xD9 or 0xD0–0xD7.
- marker_ack  in  1  consumer has handled the marker.
- protocol_err  out  1  sticky error flag; cleared only by rst.

## Operation
- Byte filter states:
  - NORMAL: an accepted byte ≠ 0xFF is appended to the accumulator. An accepted 0xFF appends nothing and moves to GOT_FF.
  - GOT_FF: the next accepted byte decides the outcome.
    - 0x00: append 0xFF, go to NORMAL.
    - 0xFF: fill byte; append nothing, stay in GOT_FF.
    - Any other value: latch it into marker_code and go to MARKER.
  - MARKER: marker_valid=1 and in_ready=0. Residual bits stay readable and consumable. On marker_ack, the residual bits are discarded (bits_avail:=0, ECS pad bits), marker_valid drops and the state returns to NORMAL.
- in_ready = !rst && state≠MARKER && bits_avail ≤ ACC_W−8. This is registered-state only, with no combinational path from consume_en.
- Update rule, applied in a single cycle: bits_avail_next = bits_avail − (consume_en ? consume_len : 0) + (append ? 8 : 0). The consume shift is applied before the new byte is appended at the LSB end.
- consume_en with consume_len > bits_avail is illegal:
  - protocol_err sets.
  - bits_avail saturates to 0.
  - Any append in the same cycle still occurs.
- consume_len > PEEK_W sets protocol_err; the consume is otherwise treated as PEEK_W.
- marker_ack while not in MARKER is ignored.

## Timing
- Reset values:
  - state=NORMAL, bits_avail=0, peek_bits=0.
  - marker_valid=0, marker_code=0x00, protocol_err=0.
  - in_ready=0 while rst is high and 1 in the first cycle after.
- Latency: a byte accepted in cycle t is visible in peek_bits and bits_avail at t+1. A consume in cycle t takes effect at t+1.
- marker_valid rises in the cycle after the marker byte is accepted. in_ready is 0 from that same cycle until the cycle after marker_ack.
- rst mid-operation (including in GOT_FF or MARKER) discards all state. A pending 0xFF is dropped.
- Throughput: one byte per cycle sustained when consume rate ≥ 8 bits/cycle.

## Structure
- Shared package jpeg_dec_pkg holds:
  - the filter state enum (NORMAL, GOT_FF, MARKER);
  - constants MRK_PREFIX=0xFF, STUFF=0x00, EOI=0xD9, RST0=0xD0, RST7=0xD7.
- Sub-module jpeg_stuff_filter is the byte-level state machine. Its outputs are an append strobe plus byte, and the marker strobe plus code.
- The top level holds the accumulator, the bit counter, peek alignment and error logic.

## Test plan
- Bytes 0xA5, 0x3C, consume off → peek_bits=0xA53C, bits_avail=16.
- Bytes 0xFF, 0x00, 0x12 → peek_bits=0xFF12, bits_avail=16; no marker.
- Bytes 0x81, 0xFF, 0xFF, 0xD9:
  - in the cycle after 0xD9, marker_valid=1, marker_code=0xD9, in_ready=0, bits_avail=8, peek_bits=0x8100;
  - marker_ack → bits_avail=0, in_ready=1.
- With bits_avail=16 and peek_bits=0xF0F0, consume_en with len=5 together with byte 0xAA → bits_avail=19, peek_bits=0x1E15.
- Fill to bits_avail=25 → in_ready=0. Consume 8 → in_ready=1 in the next cycle.
- With bits_avail=4, consume len=9 → protocol_err=1 (sticky) and bits_avail=0.
- Byte 0xFF then rst asserted, then byte 0x00 → bits_avail=8, peek_bits=0x0000, no 0xFF appended.

Source files
------------

// File: rtl/jpeg_dec_pkg.sv
// Shared types and constants for the JPEG entropy-decoder front end.
// Byte-filter state encoding plus the marker-related byte values.
package jpeg_dec_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    GOT_FF = 2'd1,
    MARKER = 2'd2
  } filt_state_e;

  localparam logic [7:0] MRK_PREFIX = 8'hFF;
  localparam logic [7:0] STUFF      = 8'h00;
  localparam logic [7:0] EOI        = 8'hD9;
  localparam logic [7:0] RST0       = 8'hD0;
  localparam logic [7:0] RST7       = 8'hD7;

endpackage

// File: rtl/jpeg_stuff_filter.sv
// Byte-level unstuffing state machine: strips 0x00 after 0xFF, swallows fill
// bytes and stops on a marker until the consumer acknowledges it.
module jpeg_stuff_filter
  import jpeg_dec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_fire,
  input  logic [7:0] byte_in,
  input  logic       marker_ack,
  output logic       append_en,
  output logic [7:0] append_byte,
  output logic       marker_valid,
  output logic [7:0] marker_code
);

  filt_state_e state_q, state_d;
  logic [7:0]  code_q, code_d;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    append_en   = 1'b0;
    append_byte = byte_in;
    unique case (state_q)
      NORMAL: begin
        if (byte_fire) begin
          if (byte_in == MRK_PREFIX) state_d = GOT_FF;
          else                       append_en = 1'b1;
        end
      end
      GOT_FF: begin
        if (byte_fire) begin
          if (byte_in == STUFF) begin
            append_en   = 1'b1;
            append_byte = MRK_PREFIX;
            state_d     = NORMAL;
          end else if (byte_in != MRK_PREFIX) begin
            code_d  = byte_in;
            state_d = MARKER;
          end
        end
      end
      MARKER: begin
        if (marker_ack) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      code_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  assign marker_valid = (state_q == MARKER);
  assign marker_code  = code_q;

endmodule

// File: rtl/jpeg_bit_reader.sv
// Bit accumulator for the Huffman decoder: MSB-aligned peek window, variable
// consume, unstuffed byte append at the LSB end, marker hold and error flag.
module jpeg_bit_reader
  import jpeg_dec_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int PEEK_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_byte,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PEEK_W-1:0]          peek_bits,
  output logic [$clog2(ACC_W+1)-1:0] bits_avail,
  input  logic                       consume_en,
  input  logic [4:0]                 consume_len,
  output logic                       marker_valid,
  output logic [7:0]                 marker_code,
  input  logic                       marker_ack,
  output logic                       protocol_err
);

  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             byte_fire;
  logic             append_en;
  logic [7:0]       append_byte;
  logic [4:0]       len_clamped;
  logic             len_err;
  logic             over_err;
  logic [ACC_W-1:0] byte_aligned;

  assign in_ready  = !rst && !marker_valid && (cnt_q <= CNT_W'(ACC_W - 8));
  assign byte_fire = in_valid && in_ready;

  jpeg_stuff_filter u_filter (
    .clk         (clk),
    .rst         (rst),
    .byte_fire   (byte_fire),
    .byte_in     (in_byte),
    .marker_ack  (marker_ack),
    .append_en   (append_en),
    .append_byte (append_byte),
    .marker_valid(marker_valid),
    .marker_code (marker_code)
  );

  // Bits beyond cnt_q are kept zero, so a left shift consumes and an OR at
  // offset cnt appends without needing a mask.
  always_comb begin
    len_clamped  = (consume_len > 5'(PEEK_W)) ? 5'(PEEK_W) : consume_len;
    len_err      = consume_en && (consume_len > 5'(PEEK_W));
    over_err     = consume_en && (CNT_W'(len_clamped) > cnt_q);
    byte_aligned = {append_byte, (ACC_W - 8)'(0)};
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    err_d        = err_q | len_err | over_err;
    if (marker_valid && marker_ack) begin
      // Residual bits before a marker are pad bits and are thrown away.
      acc_d = '0;
      cnt_d = '0;
    end else begin
      if (over_err) begin
        acc_d = '0;
        cnt_d = '0;
      end else if (consume_en) begin
        acc_d = acc_q << len_clamped;
        cnt_d = cnt_q - CNT_W'(len_clamped);
      end
      if (append_en) begin
        acc_d = acc_d | (byte_aligned >> cnt_d);
        cnt_d = cnt_d + CNT_W'(8);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign peek_bits    = acc_q[ACC_W-1 -: PEEK_W];
  assign bits_avail   = cnt_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_jpeg_bit_reader.sv
// Directed bench for jpeg_bit_reader: drives on the falling edge, samples on
// the next falling edge, expected values worked out by hand.
module tb_jpeg_bit_reader;

  localparam int ACC_W  = 32;
  localparam int PEEK_W = 16;
  localparam int CNT_W  = $clog2(ACC_W + 1);

  logic              clk;
  logic              rst;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic [PEEK_W-1:0] peek_bits;
  logic [CNT_W-1:0]  bits_avail;
  logic              consume_en;
  logic [4:0]        consume_len;
  logic              marker_valid;
  logic [7:0]        marker_code;
  logic              marker_ack;
  logic              protocol_err;

  int vectors;
  int miscompares;

  jpeg_bit_reader #(.ACC_W(ACC_W), .PEEK_W(PEEK_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .peek_bits   (peek_bits),
    .bits_avail  (bits_avail),
    .consume_en  (consume_en),
    .consume_len (consume_len),
    .marker_valid(marker_valid),
    .marker_code (marker_code),
    .marker_ack  (marker_ack),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: apply inputs at a falling edge, let one rising edge pass,
  // return to idle inputs at the next falling edge where outputs are sampled.
  task automatic step(input logic bv, input logic [7:0] b, input logic ce,
                      input logic [4:0] cl, input logic ack);
    in_valid    = bv;
    in_byte     = b;
    consume_en  = ce;
    consume_len = cl;
    marker_ack  = ack;
    @(negedge clk);
    in_valid    = 1'b0;
    in_byte     = 8'h00;
    consume_en  = 1'b0;
    consume_len = 5'd0;
    marker_ack  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic take(input logic [4:0] n);
    step(1'b0, 8'h00, 1'b1, n, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    vectors++;
    if (bits_avail !== 6'd0 || peek_bits !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_acc got bits=%0d peek=%h exp bits=0 peek=0000", bits_avail, peek_bits);
    end
    vectors++;
    if (marker_valid !== 1'b0 || marker_code !== 8'h00 || protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got mv=%b mc=%h err=%b exp 0/00/0", marker_valid, marker_code, protocol_err);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_plain();
    send(8'hA5);
    send(8'h3C);
    vectors++;
    if (peek_bits !== 16'hA53C || bits_avail !== 6'd16) begin
      miscompares++;
      $display("FAIL plain got peek=%h bits=%0d exp peek=a53c bits=16", peek_bits, bits_avail);
    end
    take(5'd16);
    vectors++;
    if (bits_avail !== 6'd0 || peek_bits !== 16'h0000) begin
      miscompares++;
      $display("FAIL plain_flush got bits=%0d peek=%h exp 0/0000", bits_avail, peek_bits);
    end
  endtask

  task automatic test_stuffing();
    send(8'hFF);
    send(8'h00);
    send(8'h12);
    vectors++;
    if (peek_bits !== 16'hFF12 || bits_avail !== 6'd16 || marker_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stuffing got peek=%h bits=%0d mv=%b exp ff12/16/0", peek_bits, bits_avail, marker_valid);
    end
    take(5'd16);
  endtask

  task automatic test_marker();
    send(8'h81);
    send(8'hFF);
    send(8'hFF);
    send(8'hD9);
    vectors++;
    if (marker_valid !== 1'b1 || marker_code !== 8'hD9 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL marker_flags got mv=%b mc=%h rdy=%b exp 1/d9/0", marker_valid, marker_code, in_ready);
    end
    vectors++;
    if (bits_avail !== 6'd8 || peek_bits !== 16'h8100) begin
      miscompares++;
      $display("FAIL marker_residual got bits=%0d peek=%h exp 8/8100", bits_avail, peek_bits);
    end
    step(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
    vectors++;
    if (bits_avail !== 6'd0 || in_ready !== 1'b1 || marker_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL marker_ack got bits=%0d rdy=%b mv=%b exp 0/1/0", bits_avail, in_ready, marker_valid);
    end
  endtask

  task automatic test_ack_ignored();
    send(8'h5A);
    step(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
    vectors++;
    if (bits_avail !== 6'd8 || peek_bits !== 16'h5A00 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_ack got bits=%0d peek=%h rdy=%b exp 8/5a00/1", bits_avail, peek_bits, in_ready);
    end
    take(5'd8);
  endtask

  task automatic test_back_to_back();
    send(8'hF0);
    send(8'hF0);
    vectors++;
    if (peek_bits !== 16'hF0F0 || bits_avail !== 6'd16) begin
      miscompares++;
      $display("FAIL b2b_setup got peek=%h bits=%0d exp f0f0/16", peek_bits, bits_avail);
    end
    step(1'b1, 8'hAA, 1'b1, 5'd5, 1'b0);
    vectors++;
    if (peek_bits !== 16'h1E15 || bits_avail !== 6'd19) begin
      miscompares++;
      $display("FAIL b2b_consume_append got peek=%h bits=%0d exp 1e15/19", peek_bits, bits_avail);
    end
    take(5'd16);
    take(5'd3);
    vectors++;
    if (bits_avail !== 6'd0 || protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_flush got bits=%0d err=%b exp 0/0", bits_avail, protocol_err);
    end
  endtask

  task automatic test_backpressure();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    vectors++;
    if (bits_avail !== 6'd24 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_24 got bits=%0d rdy=%b exp 24/1", bits_avail, in_ready);
    end
    take(5'd7);
    send(8'h44);
    vectors++;
    if (bits_avail !== 6'd25 || in_ready !== 1'b0 || peek_bits !== 16'h9119) begin
      miscompares++;
      $display("FAIL bp_25 got bits=%0d rdy=%b peek=%h exp 25/0/9119", bits_avail, in_ready, peek_bits);
    end
    take(5'd8);
    vectors++;
    if (bits_avail !== 6'd17 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got bits=%0d rdy=%b exp 17/1", bits_avail, in_ready);
    end
    take(5'd16);
    take(5'd1);
  endtask

  task automatic test_overconsume();
    send(8'h5C);
    take(5'd4);
    vectors++;
    if (bits_avail !== 6'd4 || peek_bits !== 16'hC000 || protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL over_setup got bits=%0d peek=%h err=%b exp 4/c000/0", bits_avail, peek_bits, protocol_err);
    end
    take(5'd9);
    vectors++;
    if (protocol_err !== 1'b1 || bits_avail !== 6'd0) begin
      miscompares++;
      $display("FAIL over_err got err=%b bits=%0d exp 1/0", protocol_err, bits_avail);
    end
    step(1'b1, 8'h77, 1'b1, 5'd1, 1'b0);
    vectors++;
    if (protocol_err !== 1'b1 || bits_avail !== 6'd8 || peek_bits !== 16'h7700) begin
      miscompares++;
      $display("FAIL over_with_append got err=%b bits=%0d peek=%h exp 1/8/7700", protocol_err, bits_avail, peek_bits);
    end
  endtask

  task automatic test_len_clamp();
    do_reset();
    send(8'hAB);
    send(8'hCD);
    send(8'hEF);
    take(5'd17);
    vectors++;
    if (protocol_err !== 1'b1 || bits_avail !== 6'd8 || peek_bits !== 16'hEF00) begin
      miscompares++;
      $display("FAIL len_clamp got err=%b bits=%0d peek=%h exp 1/8/ef00", protocol_err, bits_avail, peek_bits);
    end
  endtask

  task automatic test_rst_pending_ff();
    do_reset();
    send(8'hFF);
    do_reset();
    send(8'h00);
    vectors++;
    if (bits_avail !== 6'd8 || peek_bits !== 16'h0000 || marker_valid !== 1'b0 || protocol_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pending_ff got bits=%0d peek=%h mv=%b err=%b exp 8/0000/0/0",
               bits_avail, peek_bits, marker_valid, protocol_err);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_byte     = 8'h00;
    in_valid    = 1'b0;
    consume_en  = 1'b0;
    consume_len = 5'd0;
    marker_ack  = 1'b0;
    @(negedge clk);
    test_reset();
    test_plain();
    test_stuffing();
    test_marker();
    test_ack_ignored();
    test_back_to_back();
    test_backpressure();
    test_overconsume();
    test_len_clamp();
    test_rst_pending_ff();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
